pc_ra_unit: RTL and testbench

- Program-counter and return-address stage driven directly by the multicycle control FSM's PC-side strobes: writePC, PCsrc, ImRPC, writeRA, cmpeq, cmpne, backup and restore.
- Holds PC, the live return address (RA) and a hardware RA backup stack for nested cal/ret.
- Evaluates beq/bne taken conditions.
- Supplies the fetch address to instruction memory.

---
 rtl/pc_ra_unit.sv | 117 +++++++++++
 tb/tb_pc_ra_unit.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/pc_ra_unit.sv
// PC / return-address stage: fetch address, branch resolution,
// and a LIFO backup stack for nested call/return.
module pc_ra_unit #(
  parameter int               WIDTH    = 16,
  parameter int               DEPTH    = 8,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic                     clk,
  input  logic                     Reset,
  input  logic                     writePC,
  input  logic                     PCsrc,
  input  logic                     ImRPC,
  input  logic                     writeRA,
  input  logic                     cmpeq,
  input  logic                     cmpne,
  input  logic                     backup,
  input  logic                     restore,
  input  logic [11:0]              imm,
  input  logic [WIDTH-1:0]         cmp_a,
  input  logic [WIDTH-1:0]         cmp_b,
  output logic [WIDTH-1:0]         pc,
  output logic [WIDTH-1:0]         ra,
  output logic                     taken,
  output logic [$clog2(DEPTH):0]   depth,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int DW = AW + 1;

  logic [WIDTH-1:0] r_pc;
  logic [WIDTH-1:0] r_ra;
  logic             r_taken;
  logic [DW-1:0]    r_depth;
  logic             r_ovf;
  logic             r_unf;
  logic [WIDTH-1:0] r_mem [DEPTH];

  logic [WIDTH-1:0] w_jt;
  logic [WIDTH-1:0] w_bt;
  logic [WIDTH-1:0] w_inc;
  logic             w_eq;
  logic             w_br;
  logic             w_push;
  logic             w_pop;
  logic             w_full;
  logic             w_empty;
  logic [AW-1:0]    w_wi;
  logic [AW-1:0]    w_ri;

  assign w_jt    = {r_pc[WIDTH-1:13], imm, 1'b0};
  assign w_bt    = r_pc + {{(WIDTH-9){imm[7]}}, imm[7:0], 1'b0};
  assign w_inc   = r_pc + WIDTH'(2);
  assign w_eq    = (cmp_a == cmp_b);
  assign w_br    = (cmpeq & w_eq) | (cmpne & ~w_eq);
  // simultaneous push and pop cancel out
  assign w_push  = backup & ~restore;
  assign w_pop   = restore & ~backup;
  assign w_full  = (r_depth == DW'(DEPTH));
  assign w_empty = (r_depth == '0);
  assign w_wi    = r_depth[AW-1:0];
  assign w_ri    = w_wi - AW'(1);

  always_ff @(posedge clk) begin
    if (Reset) begin
      r_pc    <= RESET_PC;
      r_ra    <= '0;
      r_taken <= 1'b0;
      r_depth <= '0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else begin
      r_taken <= 1'b0;
      if (writePC) begin
        if (PCsrc) begin
          r_pc <= r_ra;
        end else if (writeRA) begin
          r_ra <= r_pc;
          r_pc <= w_jt;
        end else if (ImRPC) begin
          r_pc <= w_jt;
        end else begin
          r_pc <= w_inc;
        end
      end else if (w_br) begin
        r_pc    <= w_bt;
        r_taken <= 1'b1;
      end
      if (w_push) begin
        if (!w_full) r_depth <= r_depth + DW'(1);
        else         r_ovf   <= 1'b1;
      end
      // pop is last so it takes the ra write over a call
      if (w_pop) begin
        if (!w_empty) begin
          r_ra    <= r_mem[w_ri];
          r_depth <= r_depth - DW'(1);
        end else begin
          r_unf <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!Reset && w_push && !w_full) r_mem[w_wi] <= r_ra;
  end

  assign pc        = r_pc;
  assign ra        = r_ra;
  assign taken     = r_taken;
  assign depth     = r_depth;
  assign overflow  = r_ovf;
  assign underflow = r_unf;

endmodule

// File: tb/tb_pc_ra_unit.sv
// Bench for pc_ra_unit: directed scenarios plus random strobes,
// all checked against a queue-based reference model.
module tb_pc_ra_unit;

  localparam int W = 16;
  localparam int D = 8;
  localparam logic [W-1:0] RPC = 16'h0100;

  logic         clk = 1'b0;
  logic         Reset, writePC, PCsrc, ImRPC, writeRA;
  logic         cmpeq, cmpne, backup, restore;
  logic [11:0]  imm;
  logic [W-1:0] cmp_a, cmp_b;
  logic [W-1:0] pc, ra;
  logic         taken, overflow, underflow;
  logic [3:0]   depth;

  int n_cmp = 0;
  int n_err = 0;

  int m_pc, m_ra;
  bit m_taken, m_ovf, m_unf;
  int stk[$];

  pc_ra_unit #(.WIDTH(W), .DEPTH(D), .RESET_PC(RPC)) dut (
    .clk(clk), .Reset(Reset), .writePC(writePC), .PCsrc(PCsrc),
    .ImRPC(ImRPC), .writeRA(writeRA), .cmpeq(cmpeq), .cmpne(cmpne),
    .backup(backup), .restore(restore), .imm(imm),
    .cmp_a(cmp_a), .cmp_b(cmp_b), .pc(pc), .ra(ra), .taken(taken),
    .depth(depth), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, int got, int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    Reset = 0; writePC = 0; PCsrc = 0; ImRPC = 0; writeRA = 0;
    cmpeq = 0; cmpne = 0; backup = 0; restore = 0;
    imm = '0; cmp_a = '0; cmp_b = '0;
  endtask

  // Next-state of the architectural view, from the stated rules.
  task automatic model_edge();
    int n_pc, n_ra, jt, off;
    bit n_tk, eq;
    if (Reset) begin
      m_pc = int'(RPC); m_ra = 0; m_taken = 0;
      m_ovf = 0; m_unf = 0; stk.delete();
      return;
    end
    n_pc = m_pc; n_ra = m_ra; n_tk = 0;
    jt  = (m_pc & 'hE000) | (int'(imm) * 2);
    off = (imm[7:0] >= 128) ? int'(imm[7:0]) - 256 : int'(imm[7:0]);
    eq  = (cmp_a == cmp_b);
    if (writePC) begin
      if (PCsrc) n_pc = m_ra;
      else if (writeRA) begin n_ra = m_pc; n_pc = jt; end
      else if (ImRPC) n_pc = jt;
      else n_pc = (m_pc + 2) % 65536;
    end else if ((cmpeq && eq) || (cmpne && !eq)) begin
      n_pc = (m_pc + 2 * off + 65536) % 65536;
      n_tk = 1;
    end
    if (backup && !restore) begin
      if (stk.size() < D) stk.push_back(m_ra);
      else m_ovf = 1;
    end
    if (restore && !backup) begin
      if (stk.size() > 0) n_ra = stk.pop_back();
      else m_unf = 1;
    end
    m_pc = n_pc; m_ra = n_ra; m_taken = n_tk;
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    chk("pc", int'(pc), m_pc);
    chk("ra", int'(ra), m_ra);
    chk("taken", int'(taken), int'(m_taken));
    chk("depth", int'(depth), stk.size());
    chk("overflow", int'(overflow), int'(m_ovf));
    chk("underflow", int'(underflow), int'(m_unf));
  endtask

  initial begin
    idle();
    m_pc = 0; m_ra = 0;
    Reset = 1;
    step();
    chk("rst_pc", int'(pc), 'h0100);
    chk("rst_depth", int'(depth), 0);
    idle();

    for (int i = 0; i < 3; i++) begin
      writePC = 1;
      step();
      chk("seq_pc", int'(pc), 'h0102 + 2 * i);
    end

    // jump to 0x0010 then branch back by 4 halfwords
    idle(); writePC = 1; ImRPC = 1; imm = 12'h008;
    step();
    chk("jt_pc", int'(pc), 'h0010);
    idle(); cmpeq = 1; cmp_a = 5; cmp_b = 5; imm = 12'h0FC;
    step();
    chk("beq_pc", int'(pc), 'h0008);
    chk("beq_taken", int'(taken), 1);
    idle();
    step();
    chk("taken_drop", int'(taken), 0);
    idle(); writePC = 1; ImRPC = 1; imm = 12'h008;
    step();
    idle(); cmpne = 1; cmp_a = 5; cmp_b = 5; imm = 12'h0FC;
    step();
    chk("bne_pc", int'(pc), 'h0010);
    chk("bne_taken", int'(taken), 0);

    // compare ignored while writePC is high
    idle(); writePC = 1; cmpeq = 1; imm = 12'h0FC;
    step();
    chk("wpc_cmp_pc", int'(pc), 'h0012);

    // call then return
    idle(); writePC = 1; writeRA = 1; imm = 12'h123;
    step();
    chk("cal_pc", int'(pc), 'h0246);
    chk("cal_ra", int'(ra), 'h0012);
    idle(); backup = 1;
    step();
    chk("cal_depth", int'(depth), 1);
    idle(); writePC = 1; PCsrc = 1;
    step();
    chk("ret_pc", int'(pc), 'h0012);
    idle(); restore = 1;
    step();
    chk("ret_depth", int'(depth), 0);

    // fill past capacity, then drain past empty
    for (int i = 0; i < 9; i++) begin
      idle(); writePC = 1; writeRA = 1; imm = 12'(i * 3 + 1);
      step();
      idle(); backup = 1;
      step();
    end
    chk("full_depth", int'(depth), 8);
    chk("full_ovf", int'(overflow), 1);
    for (int i = 0; i < 9; i++) begin
      idle(); restore = 1;
      step();
    end
    chk("empty_unf", int'(underflow), 1);

    // wrap both directions around zero
    idle(); writePC = 1; ImRPC = 1; imm = 12'h000;
    step();
    idle(); cmpeq = 1; cmp_a = 7; cmp_b = 7; imm = 12'h0FF;
    step();
    chk("wrap_dn", int'(pc), 'hFFFE);
    idle(); writePC = 1;
    step();
    chk("wrap_up", int'(pc), 'h0000);
    idle(); backup = 1; restore = 1;
    step();

    // reset mid-sequence with strobes asserted
    for (int i = 0; i < 3; i++) begin
      idle(); backup = 1;
      step();
    end
    chk("pre_rst_depth", int'(depth), 3);
    idle(); Reset = 1; writePC = 1; writeRA = 1; backup = 1;
    step();
    chk("mid_rst_pc", int'(pc), 'h0100);
    chk("mid_rst_ovf", int'(overflow), 0);
    chk("mid_rst_unf", int'(underflow), 0);

    for (int i = 0; i < 3000; i++) begin
      idle();
      Reset   = ($urandom_range(0, 99) == 0);
      writePC = ($urandom_range(0, 2) == 0);
      PCsrc   = ($urandom_range(0, 3) == 0);
      ImRPC   = ($urandom_range(0, 2) == 0);
      writeRA = ($urandom_range(0, 3) == 0);
      cmpeq   = ($urandom_range(0, 2) == 0);
      cmpne   = ($urandom_range(0, 2) == 0);
      backup  = ($urandom_range(0, 3) == 0);
      restore = ($urandom_range(0, 3) == 0);
      imm     = 12'($urandom);
      cmp_a   = 16'($urandom_range(0, 3));
      cmp_b   = 16'($urandom_range(0, 3));
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
